// File: rtl/cvrt_gry_cnt.sv
// cvrt_gry_cnt: up/down counter holding both its binary value and the matching
// Gray code in flops. The Gray output is glitch-free and suited to CDC pointers.
//
// Parameters:
//   DATA_WIDTH : counter width in bits (>= 2)
//   SAT_MODE   : 0 = wrap at the range ends, 1 = saturate at all-ones / zero
//
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_en       : count enable, one step per cycle
//   i_dir      : 1 = up, 0 = down
//   i_load     : synchronous load strobe (highest priority)
//   i_load_bin : binary value to load
//   o_bin      : registered binary count
//   o_gry      : registered Gray code of o_bin
//   o_wrap     : one-cycle pulse while a wrapped value is presented
//   o_sat      : high while held at a saturation limit (SAT_MODE=1 only)
//   o_err      : sticky Gray-step violation flag (only with CVRT_GRY_CNT_CHK_EN)
//
// Optional feature macro: CVRT_GRY_CNT_CHK_EN adds the o_err checker.
module cvrt_gry_cnt #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned SAT_MODE   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_dir,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_load_bin,
    output logic [DATA_WIDTH-1:0] o_bin,
    output logic [DATA_WIDTH-1:0] o_gry,
    output logic                  o_wrap,
    output logic                  o_sat
`ifdef CVRT_GRY_CNT_CHK_EN
    ,
    output logic                  o_err
`endif
);

    localparam logic [DATA_WIDTH-1:0] MaxVal = '1;
    localparam logic [DATA_WIDTH-1:0] One    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] bin_q, bin_d;
    logic [DATA_WIDTH-1:0] gry_q, gry_d;
    logic                  wrap_q, wrap_d;
    logic                  sat_q, sat_d;
    logic                  at_lim;
    logic                  step;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        sat_d  = 1'b0;
        step   = 1'b0;
        // Limit in the requested direction: all-ones going up, zero going down.
        at_lim = i_dir ? (bin_q == MaxVal) : (bin_q == '0);
        if (i_load) begin
            bin_d = i_load_bin;
        end else if (i_en) begin
            if (at_lim && (SAT_MODE != 0)) begin
                sat_d = 1'b1;
            end else begin
                bin_d  = i_dir ? (bin_q + One) : (bin_q - One);
                wrap_d = at_lim;
                step   = 1'b1;
            end
        end
        // Gray is registered from the next binary value, never from o_bin.
        gry_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bin_q  <= '0;
            gry_q  <= '0;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gry_q  <= gry_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

    assign o_bin  = bin_q;
    assign o_gry  = gry_q;
    assign o_wrap = wrap_q;
    assign o_sat  = sat_q;

`ifdef CVRT_GRY_CNT_CHK_EN
    // prev_gry_q / step_q / load_q describe the transition that produced gry_q.
    logic [DATA_WIDTH-1:0] prev_gry_q;
    logic                  step_q;
    logic                  load_q;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] diff;
    logic                  one_hot;

    always_comb begin
        diff    = gry_q ^ prev_gry_q;
        one_hot = (diff != '0) && ((diff & (diff - One)) == '0);
        err_d   = err_q;
        if (!load_q) begin
            if (step_q) begin
                err_d = err_q | ~one_hot;
            end else begin
                err_d = err_q | (diff != '0);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_gry_q <= '0;
            step_q     <= 1'b0;
            load_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prev_gry_q <= gry_q;
            step_q     <= step;
            load_q     <= i_load;
            err_q      <= err_d;
        end
    end

    assign o_err = err_q;
`else
    // step is only consumed by the optional checker.
    logic unused_step;
    assign unused_step = step;
`endif

endmodule

// File: tb/tb_cvrt_gry_cnt.sv
// Scoreboard bench for cvrt_gry_cnt: a wrapping and a saturating instance share
// stimulus; a driver pushes model results into queues, a monitor pops and compares.
module tb_cvrt_gry_cnt;

    localparam int DW   = 4;
    localparam int MAXV = (1 << DW) - 1;

    typedef struct packed {
        logic [DW-1:0] bin;
        logic [DW-1:0] gry;
        logic          wrap;
        logic          sat;
        logic [1:0]    kind;   // 0 hold, 1 step, 2 load
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          dir;
    logic          load;
    logic [DW-1:0] load_bin;
    logic [DW-1:0] bin0, gry0, bin1, gry1;
    logic          wrap0, sat0, wrap1, sat1;
`ifdef CVRT_GRY_CNT_CHK_EN
    logic          err0, err1;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   m_bin[2];
    logic [DW-1:0] prev_gry[2];

    cvrt_gry_cnt #(.DATA_WIDTH(DW), .SAT_MODE(0)) u_wrap (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_dir      (dir),
        .i_load     (load),
        .i_load_bin (load_bin),
        .o_bin      (bin0),
        .o_gry      (gry0),
        .o_wrap     (wrap0),
        .o_sat      (sat0)
`ifdef CVRT_GRY_CNT_CHK_EN
        ,
        .o_err      (err0)
`endif
    );

    cvrt_gry_cnt #(.DATA_WIDTH(DW), .SAT_MODE(1)) u_sat (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_dir      (dir),
        .i_load     (load),
        .i_load_bin (load_bin),
        .o_bin      (bin1),
        .o_gry      (gry1),
        .o_wrap     (wrap1),
        .o_sat      (sat1)
`ifdef CVRT_GRY_CNT_CHK_EN
        ,
        .o_err      (err1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: act=still running req=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: act=%0d req=%0d @%0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: plain integer arithmetic on the count value.
    task automatic model(input int sat_mode, inout int b, input logic ld,
                         input int ldv, input logic e, input logic d, output exp_t x);
        int nb;
        x = '0;
        if (ld) begin
            b      = ldv;
            x.kind = 2;
        end else if (e) begin
            nb = d ? b + 1 : b - 1;
            if (nb < 0 || nb > MAXV) begin
                if (sat_mode != 0) begin
                    x.sat  = 1'b1;
                    x.kind = 0;
                end else begin
                    b      = (nb + MAXV + 1) % (MAXV + 1);
                    x.wrap = 1'b1;
                    x.kind = 1;
                end
            end else begin
                b      = nb;
                x.kind = 1;
            end
        end
        x.bin = DW'(b);
        x.gry = DW'(b ^ (b >> 1));
    endtask

    task automatic drive(input logic ld, input int ldv, input logic e, input logic d);
        exp_t x0, x1;
        int   b0, b1;
        @(negedge clk);
        load     = ld;
        load_bin = DW'(ldv);
        en       = e;
        dir      = d;
        b0 = m_bin[0];
        b1 = m_bin[1];
        model(0, b0, ld, ldv, e, d, x0);
        model(1, b1, ld, ldv, e, d, x1);
        m_bin[0] = b0;
        m_bin[1] = b1;
        q0.push_back(x0);
        q1.push_back(x1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " bin0"}, int'(bin0), 0);
        check({tag, " gry0"}, int'(gry0), 0);
        check({tag, " wrap0"}, int'(wrap0), 0);
        check({tag, " bin1"}, int'(bin1), 0);
        check({tag, " gry1"}, int'(gry1), 0);
        check({tag, " sat1"}, int'(sat1), 0);
    endtask

    // Asserts reset mid-cycle with en high; outputs must clear before the next edge.
    task automatic mid_reset();
        @(negedge clk);
        en   = 1'b1;
        dir  = 1'b1;
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("async reset");
        m_bin[0]    = 0;
        m_bin[1]    = 0;
        prev_gry[0] = '0;
        prev_gry[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
    endtask

    // Monitor: the DUT presents a value every cycle; compare once per edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                x = q0.pop_front();
                check("wrap bin", int'(bin0), int'(x.bin));
                check("wrap gry", int'(gry0), int'(x.gry));
                check("wrap o_wrap", int'(wrap0), int'(x.wrap));
                check("wrap o_sat", int'(sat0), int'(x.sat));
                if (x.kind == 1) check("wrap gray one-bit", $countones(gry0 ^ prev_gry[0]), 1);
                if (x.kind == 0) check("wrap gray hold", int'(gry0), int'(prev_gry[0]));
                prev_gry[0] = gry0;
            end
            if (q1.size() > 0) begin
                x = q1.pop_front();
                check("sat bin", int'(bin1), int'(x.bin));
                check("sat gry", int'(gry1), int'(x.gry));
                check("sat o_wrap", int'(wrap1), int'(x.wrap));
                check("sat o_sat", int'(sat1), int'(x.sat));
                if (x.kind == 1) check("sat gray one-bit", $countones(gry1 ^ prev_gry[1]), 1);
                if (x.kind == 0) check("sat gray hold", int'(gry1), int'(prev_gry[1]));
                prev_gry[1] = gry1;
            end
`ifdef CVRT_GRY_CNT_CHK_EN
            if (rst_n) begin
                check("wrap o_err", int'(err0), 0);
                check("sat o_err", int'(err1), 0);
            end
`endif
        end
    end

    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        dir         = 1'b0;
        load        = 1'b0;
        load_bin    = '0;
        m_bin[0]    = 0;
        m_bin[1]    = 0;
        prev_gry[0] = '0;
        prev_gry[1] = '0;
        #3 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full up cycle including the wrap back to zero.
        for (int i = 0; i < 17; i++) drive(1'b0, 0, 1'b1, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);
        // Down-wrap from zero, then a normal down step.
        drive(1'b1, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        // Load has priority over a simultaneous count.
        drive(1'b1, 4'b1010, 1'b1, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b0);
        // Saturation at all-ones, then release by the opposite direction.
        drive(1'b1, 4'b1110, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b1, 1'b1);
        drive(1'b0, 0, 1'b1, 1'b0);
        // Saturation at zero.
        drive(1'b1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b1, 1'b0);
        // Direction reversal returns to the prior value.
        drive(1'b1, 7, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b1);
        drive(1'b0, 0, 1'b1, 1'b0);
        // Count to 0101, then reset mid-cycle and restart.
        drive(1'b1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 0, 1'b1, 1'b1);
        mid_reset();
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b1, 1'b1);

        // Random mix of load / count / hold.
        for (int i = 0; i < 1000; i++) begin
            logic r_ld, r_en, r_dir;
            r_ld  = ($urandom_range(0, 7) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_dir = 1'($urandom_range(0, 1));
            drive(r_ld, int'($urandom_range(0, MAXV)), r_en, r_dir);
        end
        drive(1'b0, 0, 1'b0, 1'b0);

        // Bounded drain of anything still queued.
        for (int i = 0; i < 5 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
        #2;
        check("scoreboard drained", q0.size() + q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
